fib_result_capture: RTL and testbench

- Sits directly downstream of the microprocessor core's register-file write port. Snoops every write-back and captures the values written to one designated result register (the Fibonacci output register).
- Buffers captured values in a FIFO and presents them on a valid/ready stream to the display/UART side.
- Detects program halt (PC parked in a self-loop) and raises done once all captured results have drained.

---
 rtl/fib_result_capture.sv | 134 +++++++++++++
 tb/tb_fib_result_capture.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_result_capture.sv
// Snoops core register write-backs, buffers writes to the result register in a
// first-word-fall-through FIFO, and flags halt once the PC sits in a self-loop.
//
// state  | meaning
// IDLE   | capture disarmed, waiting for capture_en
// RUN    | capturing result-register writes, watching PC for a self-loop
// HALTED | program parked; no captures until clear
module fib_result_capture #(
    parameter int DATA_WIDTH  = 32,
    parameter int DIR_WIDTH   = 5,
    parameter int DEPTH       = 8,
    parameter int RESULT_REG  = 10,
    parameter int HALT_CYCLES = 3
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       regwrite,
    input  logic [DIR_WIDTH-1:0]       write_dir,
    input  logic [DATA_WIDTH-1:0]      write_data,
    input  logic [DATA_WIDTH-1:0]      pc,
    input  logic                       capture_en,
    input  logic                       clear,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic                       halted,
    output logic                       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(HALT_CYCLES) + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] prev_pc;
    logic [SW-1:0]         stable_cnt, stable_nxt;
    logic                  pc_same;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  push_req, pop, full, push_ok, drop;

    assign pc_same = (pc == prev_pc);

    always_comb begin
        state_nxt  = state;
        stable_nxt = '0;
        case (state)
            IDLE: begin
                if (capture_en) state_nxt = RUN;
            end
            RUN: begin
                if (!capture_en) begin
                    state_nxt = IDLE;
                end else if (pc_same && stable_cnt == SW'(HALT_CYCLES - 1)) begin
                    state_nxt = HALTED;
                end else if (pc_same) begin
                    stable_nxt = stable_cnt + SW'(1);
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt  = IDLE;
            stable_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= IDLE;
            stable_cnt <= '0;
            prev_pc    <= '0;
        end else begin
            state      <= state_nxt;
            stable_cnt <= stable_nxt;
            prev_pc    <= pc;
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_req = (state == RUN) && regwrite && (write_dir == DIR_WIDTH'(RESULT_REG)) && !clear;
    assign pop      = out_valid && out_ready && !clear;
    assign full     = (count == CW'(DEPTH));
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= write_data;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    // Head is masked while empty so outputs read 0 straight out of reset.
    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign halted    = (state == HALTED);
    assign done      = halted && (count == '0);

    assert property (@(posedge clk) RESULT_REG != 0);

endmodule

// File: tb/tb_fib_result_capture.sv
// Randomized and directed bench for fib_result_capture, checked against a
// queue-based behavioural model of the capture FIFO and halt detector.
module tb_fib_result_capture;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int HALT  = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          regwrite;
    logic [4:0]    write_dir;
    logic [DW-1:0] write_data;
    logic [DW-1:0] pc;
    logic          capture_en;
    logic          clear;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [3:0]    count;
    logic          overflow;
    logic [7:0]    drop_count;
    logic          halted;
    logic          done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mq[$];
    int            m_mode;
    logic [DW-1:0] m_prev_pc;
    int            m_stable;
    bit            m_ovf;
    int            m_drop;

    fib_result_capture dut (
        .clk(clk), .arst_n(arst_n), .regwrite(regwrite), .write_dir(write_dir),
        .write_data(write_data), .pc(pc), .capture_en(capture_en), .clear(clear),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .overflow(overflow), .drop_count(drop_count),
        .halted(halted), .done(done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_mode = M_IDLE; m_prev_pc = '0; m_stable = 0; m_ovf = 0; m_drop = 0;
    endtask

    // One clock of the specified behaviour, evaluated on the inputs present before the edge.
    task automatic model_step();
        bit push, pop, was_full;
        if (clear) begin
            mq.delete(); m_ovf = 0; m_drop = 0; m_mode = M_IDLE; m_stable = 0;
            m_prev_pc = pc;
            return;
        end
        push     = (m_mode == M_RUN) && regwrite && (write_dir == 5'd10);
        pop      = (mq.size() > 0) && out_ready;
        was_full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (!was_full || pop) mq.push_back(write_data);
            else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        case (m_mode)
            M_IDLE: begin
                m_stable = 0;
                if (capture_en) m_mode = M_RUN;
            end
            M_RUN: begin
                if (!capture_en) begin
                    m_mode = M_IDLE; m_stable = 0;
                end else if (pc == m_prev_pc) begin
                    m_stable++;
                    if (m_stable == HALT) begin m_mode = M_HALTED; m_stable = 0; end
                end else m_stable = 0;
            end
            default: ;
        endcase
        m_prev_pc = pc;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        regwrite = 0; write_dir = '0; write_data = '0; out_ready = 0; clear = 0;
    endtask

    task automatic apply_reset();
        arst_n = 0;
        #3;
        model_reset();
        @(negedge clk);
        arst_n = 1;
    endtask

    task automatic test_reset();
        idle_inputs(); capture_en = 0; pc = '0;
        apply_reset();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got %0h want 0", out_data); end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_tests++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_overflow got %0b/%0d want 0/0", overflow, drop_count); end
        n_tests++; if (halted !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_halt got %0b/%0b want 0/0", halted, done); end
    endtask

    task automatic test_fib_stream();
        logic [DW-1:0] fib [5] = '{0, 1, 1, 2, 3};
        capture_en = 1; pc = 32'h100;
        tick();
        for (int i = 0; i < 5; i++) begin
            regwrite = 1; write_dir = 5'd10; write_data = fib[i]; out_ready = 1; pc += 4;
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_data !== fib[i]) begin n_fail++; $display("FAIL fib_head[%0d] got %0b/%0h want 1/%0h", i, out_valid, out_data, fib[i]); end
            n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL fib_count[%0d] got %0d want 1", i, count); end
        end
        regwrite = 0; pc += 4;
        tick();
        n_tests++; if (count !== 4'd0 || overflow !== 1'b0) begin n_fail++; $display("FAIL fib_end got %0d/%0b want 0/0", count, overflow); end
    endtask

    task automatic test_no_capture();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            regwrite = (i % 2 == 0); write_dir = (i % 2 == 0) ? 5'd5 : 5'd10;
            write_data = $urandom; pc += 4;
            tick();
            n_tests++; if (count !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL no_capture[%0d] got count %0d valid %0b want 0/0", i, count, out_valid); end
        end
    endtask

    task automatic test_overflow_and_full_pushpop();
        logic [DW-1:0] drain [8] = '{2, 3, 4, 5, 6, 7, 8, 99};
        out_ready = 0; regwrite = 1; write_dir = 5'd10;
        for (int v = 1; v <= 10; v++) begin
            write_data = DW'(v); pc += 4;
            tick();
        end
        n_tests++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", count); end
        n_tests++; if (overflow !== 1'b1 || drop_count !== 8'd2) begin n_fail++; $display("FAIL ovf_drops got %0b/%0d want 1/2", overflow, drop_count); end
        n_tests++; if (out_data !== 32'd1) begin n_fail++; $display("FAIL ovf_head got %0h want 1", out_data); end
        write_data = 99; out_ready = 1; pc += 4;
        tick();
        n_tests++; if (count !== 4'd8 || drop_count !== 8'd2) begin n_fail++; $display("FAIL full_pushpop got %0d/%0d want 8/2", count, drop_count); end
        regwrite = 0;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (out_valid !== 1'b1 || out_data !== drain[i]) begin n_fail++; $display("FAIL drain[%0d] got %0b/%0h want 1/%0h", i, out_valid, out_data, drain[i]); end
            pc += 4;
            tick();
        end
        n_tests++; if (count !== 4'd0 || overflow !== 1'b1) begin n_fail++; $display("FAIL drain_end got %0d/%0b want 0/1", count, overflow); end
    endtask

    task automatic test_halt();
        bit seen;
        idle_inputs(); clear = 1; pc = 32'h1000;
        tick();
        clear = 0; pc += 4;
        tick();
        regwrite = 1; write_dir = 5'd10;
        for (int i = 0; i < 2; i++) begin
            write_data = $urandom; pc += 4;
            tick();
        end
        regwrite = 0; pc = 32'h40;
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            n_tests++; if (halted !== (m_mode == M_HALTED)) begin n_fail++; $display("FAIL halt_step[%0d] got %0b want %0b", i, halted, m_mode == M_HALTED); end
            seen = halted;
        end
        n_tests++; if (halted !== 1'b1 || done !== 1'b0 || count !== 4'd2) begin n_fail++; $display("FAIL halt_buffered got %0b/%0b/%0d want 1/0/2", halted, done, count); end
        out_ready = 1;
        tick();
        tick();
        n_tests++; if (done !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL halt_done got %0b/%0d want 1/0", done, count); end
        out_ready = 0; regwrite = 1; write_data = 77;
        tick();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL halt_no_capture got %0d want 0", count); end
        regwrite = 0; clear = 1;
        tick();
        clear = 0;
        n_tests++; if (halted !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL halt_clear got %0b/%0b want 0/0", halted, done); end
        capture_en = 0; regwrite = 1; write_data = 55;
        for (int i = 0; i < 3; i++) begin
            pc += 4;
            tick();
            n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL disarmed_capture[%0d] got %0d want 0", i, count); end
        end
    endtask

    task automatic test_reset_mid();
        capture_en = 1; regwrite = 0; pc += 4;
        tick();
        regwrite = 1; write_dir = 5'd10; out_ready = 0;
        for (int i = 0; i < 4; i++) begin
            write_data = $urandom; pc += 4;
            tick();
        end
        n_tests++; if (count !== 4'd4) begin n_fail++; $display("FAIL mid_prefill got %0d want 4", count); end
        #2;
        arst_n = 0;
        #1;
        n_tests++; if (count !== 4'd0 || out_valid !== 1'b0 || capture_en !== 1'b1) begin n_fail++; $display("FAIL mid_reset got %0d/%0b want 0/0", count, out_valid); end
        model_reset();
        idle_inputs(); capture_en = 0;
        @(negedge clk);
        arst_n = 1;
    endtask

    task automatic test_random();
        int fails_before;
        for (int i = 0; i < 500; i++) begin
            capture_en = ($urandom % 8) != 0;
            clear      = ($urandom % 30) == 0;
            regwrite   = $urandom % 2;
            write_dir  = ($urandom % 3 == 0) ? 5'($urandom) : 5'd10;
            write_data = $urandom;
            out_ready  = ($urandom % 3) == 0;
            if ($urandom % 3 != 0) pc = $urandom;
            tick();
            fails_before = n_fail;
            n_tests++; if (count !== 4'(mq.size())) begin n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, count, mq.size()); end
            n_tests++; if (out_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got %0b want %0b", i, out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                n_tests++; if (out_data !== mq[0]) begin n_fail++; $display("FAIL rnd_data[%0d] got %0h want %0h", i, out_data, mq[0]); end
            end
            n_tests++; if (overflow !== m_ovf || drop_count !== 8'(m_drop)) begin n_fail++; $display("FAIL rnd_drop[%0d] got %0b/%0d want %0b/%0d", i, overflow, drop_count, m_ovf, m_drop); end
            n_tests++; if (halted !== (m_mode == M_HALTED)) begin n_fail++; $display("FAIL rnd_halted[%0d] got %0b want %0b", i, halted, m_mode == M_HALTED); end
            n_tests++; if (done !== (m_mode == M_HALTED && mq.size() == 0)) begin n_fail++; $display("FAIL rnd_done[%0d] got %0b", i, done); end
            if (n_fail != fails_before) begin
                // Resynchronise model and DUT so one divergence does not cascade.
                idle_inputs(); capture_en = 0;
                apply_reset();
            end
        end
    endtask

    initial begin
        test_reset();
        test_fib_stream();
        test_no_capture();
        test_overflow_and_full_pushpop();
        test_halt();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

endmodule
